// File: rtl/matmul_operand_store.sv
// rtl/matmul_operand_store.sv - operand/result store for the matrix-multiply engine
// Holds A/B for zero-latency vector reads, captures C writes and checks run completion.
module matmul_operand_store #(
  parameter int DATA_BIT_WIDTH   = 32,
  parameter int DIM_INDEX_WIDTH  = 3,
  parameter int DIM_SIZE         = 2**DIM_INDEX_WIDTH,
  parameter int TOTAL_ADDR_WIDTH = DIM_INDEX_WIDTH*2,
  parameter int TOTAL_MAT_SIZE   = 2**TOTAL_ADDR_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     ld_valid,
  output logic                                     ld_ready,
  input  logic                                     ld_sel,
  input  logic [TOTAL_ADDR_WIDTH-1:0]              ld_addr,
  input  logic [DATA_BIT_WIDTH-1:0]                ld_data,
  input  logic                                     go,
  output logic                                     start_cmd,
  input  logic [DIM_INDEX_WIDTH-1:0]               next_row_req,
  input  logic [DIM_INDEX_WIDTH-1:0]               next_col_req,
  output logic [DIM_SIZE-1:0][DATA_BIT_WIDTH-1:0]  row_data_out,
  output logic [DIM_SIZE-1:0][DATA_BIT_WIDTH-1:0]  col_data_out,
  input  logic                                     res_write_en,
  input  logic [TOTAL_ADDR_WIDTH-1:0]              res_write_addr,
  input  logic [DATA_BIT_WIDTH-1:0]                res_write_data,
  input  logic                                     exec_done,
  input  logic [TOTAL_ADDR_WIDTH-1:0]              rd_addr,
  output logic [DATA_BIT_WIDTH-1:0]                rd_data,
  output logic                                     busy,
  output logic                                     results_valid,
  output logic                                     err_unexpected,
  output logic                                     err_count
);

  localparam int CW = TOTAL_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(TOTAL_MAT_SIZE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;
  logic [DATA_BIT_WIDTH-1:0] a_mem [TOTAL_MAT_SIZE];
  logic [DATA_BIT_WIDTH-1:0] b_mem [TOTAL_MAT_SIZE];
  logic [DATA_BIT_WIDTH-1:0] c_mem [TOTAL_MAT_SIZE];
  logic [CW-1:0] wr_count;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] count_final;

  assign ld_ready = (state == IDLE);

  // Counter saturates so an over-long run can never wrap back onto FULL.
  always_comb begin
    count_inc   = (wr_count == FULL) ? FULL : wr_count + CW'(1);
    count_final = res_write_en ? count_inc : wr_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TOTAL_MAT_SIZE; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (ld_valid && ld_ready) begin
      if (ld_sel) b_mem[ld_addr] <= ld_data;
      else        a_mem[ld_addr] <= ld_data;
    end
  end

  for (genvar g = 0; g < DIM_SIZE; g++) begin : g_vec
    assign row_data_out[g] = a_mem[{next_row_req, DIM_INDEX_WIDTH'(g)}];
    assign col_data_out[g] = b_mem[{DIM_INDEX_WIDTH'(g), next_col_req}];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      start_cmd      <= 1'b0;
      busy           <= 1'b0;
      results_valid  <= 1'b0;
      err_unexpected <= 1'b0;
      err_count      <= 1'b0;
      wr_count       <= '0;
      rd_data        <= '0;
      for (int i = 0; i < TOTAL_MAT_SIZE; i++) c_mem[i] <= '0;
    end else begin
      rd_data   <= c_mem[rd_addr];
      start_cmd <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state          <= RUN;
            start_cmd      <= 1'b1;
            busy           <= 1'b1;
            wr_count       <= '0;
            results_valid  <= 1'b0;
            err_unexpected <= 1'b0;
            err_count      <= 1'b0;
          end
          // Stray engine activity outside a run is flagged, never stored.
          if (res_write_en || exec_done) err_unexpected <= 1'b1;
        end
        RUN: begin
          if (res_write_en) begin
            c_mem[res_write_addr] <= res_write_data;
            wr_count              <= count_inc;
          end
          if (exec_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (count_final == FULL) results_valid <= 1'b1;
            else                     err_count     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/matmul_operand_store.md
Name: matmul_operand_store

Overview:
- Memory-side responder for the matrix-multiply engine's operand-request and result-write interface.
- Holds operand matrices A and B, which the host loads through a valid/ready port.
- Issues the engine's start pulse, answers row/column requests with zero-latency vector reads, and captures the engine's result writes into a result matrix C.
- Checks completion and exposes C to the host through a registered read port.

Parameters:
- DATA_BIT_WIDTH, 32, element width.
- DIM_INDEX_WIDTH, 3, row/column index width.
- DIM_SIZE, 2**DIM_INDEX_WIDTH, matrix dimension.
- TOTAL_ADDR_WIDTH, DIM_INDEX_WIDTH*2, flat element address width (row*DIM_SIZE+col).
- TOTAL_MAT_SIZE, 2**TOTAL_ADDR_WIDTH, elements per matrix.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ld_valid  in  1  host load beat valid.
- ld_ready  out  1  load beat accepted when ld_valid&&ld_ready.
- ld_sel  in  1  0 = write A, 1 = write B.
- ld_addr  in  TOTAL_ADDR_WIDTH  flat element address, row-major.
- ld_data  in  DATA_BIT_WIDTH  element value.
- go  in  1  host request to run a multiply.
- start_cmd  out  1  one-cycle start pulse to the engine.
- next_row_req  in  DIM_INDEX_WIDTH  row index requested by the engine.
- next_col_req  in  DIM_INDEX_WIDTH  column index requested by the engine.
- row_data_out  out  DIM_SIZE x DATA_BIT_WIDTH  element k = A[next_row_req][k].
- col_data_out  out  DIM_SIZE x DATA_BIT_WIDTH  element k = B[k][next_col_req].
- res_write_en  in  1  engine result write strobe.
- res_write_addr  in  TOTAL_ADDR_WIDTH  result flat address.
- res_write_data  in  DATA_BIT_WIDTH  result value.
- exec_done  in  1  engine completion pulse.
- rd_addr  in  TOTAL_ADDR_WIDTH  host result read address.
- rd_data  out  DATA_BIT_WIDTH  C[rd_addr], registered.
- busy  out  1  high in RUN.
- results_valid  out  1  C complete and error-free.
- err_unexpected  out  1  sticky: write or done seen outside RUN.
- err_count  out  1  sticky: exec_done with write count != TOTAL_MAT_SIZE.

Behaviour:
- Reset: state IDLE; A, B and C cleared to 0; start_cmd=0, busy=0, results_valid=0, err_unexpected=0, err_count=0, rd_data=0, write counter=0.
- State IDLE:
  - ld_ready=1; an accepted beat writes A or B at the clock edge.
  - go (registered) drives start_cmd=1 for exactly one cycle in the following cycle and moves to RUN.
  - On that same go edge: clear write counter, results_valid, err_unexpected and err_count.
  - A load beat in the same cycle as go is accepted and is visible before the engine's first request.
- State RUN:
  - ld_ready=0, busy=1; go is ignored.
  - Each res_write_en writes C[res_write_addr]=res_write_data and increments the counter (width TOTAL_ADDR_WIDTH+1, saturating at TOTAL_MAT_SIZE).
  - exec_done moves to IDLE. The write in the same cycle as exec_done counts toward the total.
  - At exec_done: if the counter including the same-cycle write equals TOTAL_MAT_SIZE, set results_valid=1; otherwise set err_count=1 and leave results_valid=0.
- Operand reads: row_data_out and col_data_out are purely combinational from the arrays and request indices (zero latency). The engine samples data in the same cycle it presents an index.
- Host read port: rd_data = C[rd_addr] registered, one-cycle latency, available in any state. A read of an address written in the same cycle returns the old value.
- res_write_en or exec_done in IDLE: write ignored, err_unexpected=1.
- Duplicate result addresses are counted, not detected; a short run with a duplicate is flagged only via err_count.
- Reset mid-RUN returns to IDLE with all arrays and flags cleared. The host is responsible for also resetting the engine.
- Indices are exactly DIM_INDEX_WIDTH wide; no out-of-range case exists.

Test Plan:
- Load A=identity, B[r][c]=r*8+c; pulse go; connect the engine -> start_cmd high for 1 cycle, busy until exec_done, 64 writes, results_valid=1; reading C[0x2B] returns 43.
- Load A all 2, B all 3 -> every C element reads 48 (8*2*3); rd_data appears one cycle after rd_addr.
- In IDLE, set next_row_req=5, next_col_req=2 -> row_data_out = A row 5 and col_data_out = B column 2 in the same cycle, with no clock edge needed.
- Stub engine issues 63 writes then exec_done -> err_count=1, results_valid=0; the next go clears both.
- Drive res_write_en in IDLE with addr 0, data 0xDEAD -> err_unexpected=1, C[0] unchanged.
- Assert rst 10 cycles into RUN -> busy=0, all flags 0, C[0] reads 0, ld_ready=1 on the next cycle.
